ram_byte_write_packer: RTL
==========================

// Module: ram_byte_write_packer
// PURPOSE
// Write-side initiator for the byte-enable dual-port RAM. Accepts a stream of single-byte writes
// (byte address + data), merges bytes that fall in the same 32-bit word into one buffer, and
// issues word writes with per-byte enables on the RAM write port (wr_en/byte_en/wr_addr/wr_data).
// Sits between byte-granular producers (UART/DMA byte engines) and the RAM; it cuts write traffic.
// PARAMETERS
// ADDR_W   8    RAM word-address width; byte address is ADDR_W+2 bits
// TIMEOUT  16   idle cycles a partly filled buffer may wait before a forced write (>=1)
// PORTS
// clk       in   1         clock, all logic on rising edge
// rst       in   1         asynchronous reset, active-high
// in_valid  in   1         byte write request
// in_ready  out  1         byte accepted when in_valid & in_ready
// in_addr   in   ADDR_W+2  byte address: [ADDR_W+1:2]=word address, [1:0]=lane
// in_data   in   8         byte data
// flush     in   1         one-cycle pulse: write out the buffer if it is non-empty
// wr_en     out  1         RAM write strobe, one-cycle pulse per word write
// byte_en   out  4         RAM byte enables, [k] covers wr_data[8k+7:8k]
// wr_addr   out  ADDR_W    RAM word address
// wr_data   out  32        RAM write data, lanes without an enable are 0
// busy      out  1         buffer non-empty or a write is pending
// BEHAVIOUR
// - Reset (async, any state): buffer, enables, timeout counter and pending flags cleared.
//   wr_en=0, byte_en=0, wr_addr=0, wr_data=0, in_ready=0, busy=0. A partly filled buffer is discarded.
// - in_ready=1 in every cycle after reset is released. The block never back-pressures.
// - States: EMPTY (no lanes valid) and FILL (>=1 lane valid, buf_addr valid).
// - Accept in EMPTY: buf_addr<=word addr, lane<=in_data, lane enable set -> FILL.
// - Accept in FILL with the same word address: merge the lane. A repeated lane is overwritten (last wins).
// - Accept in FILL with a different word address: the current buffer is written. The buffer then
//   reloads with the new byte in the same cycle and stays in FILL.
// - Write triggers, sampled at the rising edge of cycle N. The write appears on the registered
//   outputs in cycle N+1, with wr_en high for exactly 1 cycle.
//   (a) address mismatch as above.
//   (b) all 4 enables set after the merge. The buffer clears and the state goes to EMPTY.
//   (c) flush=1 in FILL. Buffer clears -> EMPTY.
//   (d) timeout counter == TIMEOUT. Buffer clears -> EMPTY.
// - Timeout counter: cleared on every accepted byte and in EMPTY. It increments by 1 in each FILL
//   cycle with no accepted byte. A byte accepted in cycle N with no later traffic gives wr_en in
//   cycle N+TIMEOUT+1.
// - flush with in_valid in the same cycle: the byte is merged first, then the merged buffer is written.
// - flush in EMPTY with no in_valid: no-op, no write.
// - Several triggers in one cycle produce one write, except mismatch+flush. In that case the old
//   word is written at N+1. flush_pend is set, and the new single-byte word is written at N+2.
// - A new accepted byte at N+1 that matches the pending word merges before the N+2 write.
// - Writes always issue in arrival order. The RAM write port never sees two different words in one cycle.
// - When wr_en=0, byte_en, wr_addr and wr_data hold their last written values. The RAM ignores them.
// - busy = FILL | flush_pend | wr_en.
// TESTING
// 1. Bytes 11,22,33,44 to 0x010..0x013 on consecutive cycles -> 1 cycle after the 4th byte:
//    wr_en=1, wr_addr=0x04, byte_en=F, wr_data=0x44332211. No other wr_en pulse.
// 2. Byte AA to 0x021, then flush 3 cycles later -> wr_addr=0x08, byte_en=0010, wr_data=0x0000AA00.
// 3. Byte 55 to 0x030 at cycle N, then idle, TIMEOUT=16 -> wr_en only at N+17, wr_addr=0x0C,
//    byte_en=0001, wr_data=0x00000055.
// 4. Byte 01 to 0x040, then byte 02 to 0x044 with flush in the same cycle -> write {0x10,0001,0x01}
//    at N+1, then write {0x11,0001,0x02} at N+2.
// 5. Byte 11 then byte 99 to 0x050, then flush -> wr_data[7:0]=0x99, byte_en=0001.
// 6. Bytes to 0x060 and 0x061, rst asserted mid-cycle -> outputs 0 immediately, no wr_en.
//    Flush after release -> no write, busy=0.

Source files
------------

// File: rtl/ram_byte_write_packer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ram_byte_write_packer : merges byte writes into word writes with byte enables
// Rev 1.0
// ---------------------------------------------------------------------------
module ram_byte_write_packer #(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W+1:0] in_addr,
  input  logic [7:0]        in_data,
  input  logic              flush,
  output logic              wr_en,
  output logic [3:0]        byte_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              busy
);

  localparam int             CNT_W     = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] C_TIMEOUT = CNT_W'(TIMEOUT);

  typedef enum logic [0:0] {
    S_EMPTY = 1'b0,
    S_FILL  = 1'b1
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_buf_addr;
  logic [31:0]       r_buf_data;
  logic [3:0]        r_buf_en;
  logic [CNT_W-1:0]  r_tcnt;
  logic              r_flush_pend;

  logic              w_accept;
  logic              w_fill;
  logic [ADDR_W-1:0] w_word;
  logic [1:0]        w_lane;
  logic [3:0]        w_lane_en;
  logic [31:0]       w_lane_data;
  logic [31:0]       w_lane_mask;
  logic              w_mismatch;
  logic              w_hit;
  logic [3:0]        w_merged_en;
  logic [31:0]       w_merged_data;
  logic [ADDR_W-1:0] w_merged_addr;
  logic [CNT_W-1:0]  w_tcnt_inc;
  logic              w_timeout;
  logic              w_write_merged;

  assign w_accept    = in_valid & in_ready;
  assign w_fill      = (r_state == S_FILL);
  assign w_word      = in_addr[ADDR_W+1:2];
  assign w_lane      = in_addr[1:0];
  assign w_lane_en   = 4'b0001 << w_lane;
  assign w_lane_data = {24'b0, in_data} << {w_lane, 3'b000};
  assign w_lane_mask = {{8{w_lane_en[3]}}, {8{w_lane_en[2]}},
                        {8{w_lane_en[1]}}, {8{w_lane_en[0]}}};

  // A byte for another word flushes the old word; anything else merges (or loads when empty).
  assign w_mismatch = w_accept & w_fill & (w_word != r_buf_addr);
  assign w_hit      = w_accept & ~w_mismatch;

  assign w_merged_en   = (w_fill ? r_buf_en : 4'b0) | (w_hit ? w_lane_en : 4'b0);
  assign w_merged_data = ((w_fill ? r_buf_data : 32'b0) & ~(w_hit ? w_lane_mask : 32'b0))
                       | (w_hit ? w_lane_data : 32'b0);
  assign w_merged_addr = (w_fill || !w_accept) ? r_buf_addr : w_word;

  // The counter counts idle FILL cycles; the write fires on the cycle it would reach TIMEOUT.
  assign w_tcnt_inc = r_tcnt + 1'b1;
  assign w_timeout  = w_fill & ~w_accept & (w_tcnt_inc == C_TIMEOUT);

  assign w_write_merged = ~w_mismatch & (|w_merged_en)
                        & ((&w_merged_en) | flush | r_flush_pend | w_timeout);

  assign busy = w_fill | r_flush_pend | wr_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_EMPTY;
      r_buf_addr   <= '0;
      r_buf_data   <= '0;
      r_buf_en     <= '0;
      r_tcnt       <= '0;
      r_flush_pend <= 1'b0;
      in_ready     <= 1'b0;
      wr_en        <= 1'b0;
      byte_en      <= '0;
      wr_addr      <= '0;
      wr_data      <= '0;
    end else begin
      in_ready     <= 1'b1;
      wr_en        <= 1'b0;
      r_flush_pend <= 1'b0;
      if (w_mismatch) begin
        wr_en        <= 1'b1;
        byte_en      <= r_buf_en;
        wr_addr      <= r_buf_addr;
        wr_data      <= r_buf_data;
        r_buf_addr   <= w_word;
        r_buf_en     <= w_lane_en;
        r_buf_data   <= w_lane_data;
        r_tcnt       <= '0;
        r_state      <= S_FILL;
        // The new byte is still owed a write if a flush arrived alongside it.
        r_flush_pend <= flush;
      end else if (w_write_merged) begin
        wr_en      <= 1'b1;
        byte_en    <= w_merged_en;
        wr_addr    <= w_merged_addr;
        wr_data    <= w_merged_data;
        r_buf_en   <= '0;
        r_buf_data <= '0;
        r_tcnt     <= '0;
        r_state    <= S_EMPTY;
      end else begin
        r_buf_addr <= w_merged_addr;
        r_buf_en   <= w_merged_en;
        r_buf_data <= w_merged_data;
        r_tcnt     <= (w_fill && !w_accept) ? w_tcnt_inc : '0;
        r_state    <= (|w_merged_en) ? S_FILL : S_EMPTY;
      end
    end
  end

endmodule
`default_nettype wire
